// File: rtl/fighter_pose_sequencer_pkg.sv
// Shared types for the fighter pose sequencer.
// Pose encoding matches the colour-mapper ROM mux.
package fighter_pkg;

  localparam int SPR_W = 64;

  typedef enum logic [3:0] {
    STAND       = 4'd0,
    CROUCH      = 4'd1,
    JUMP        = 4'd2,
    KICK        = 4'd3,
    PUNCH       = 4'd4,
    BLOCK       = 4'd5,
    CROUCHPUNCH = 4'd6,
    DEAD        = 4'd7,
    STAND2      = 4'd8,
    MOVE        = 4'd9
  } pose_t;

  function automatic logic is_attack(pose_t p);
    return (p == PUNCH) || (p == KICK) ||
           (p == CROUCHPUNCH);
  endfunction

  function automatic logic is_timed(pose_t p);
    return is_attack(p) || (p == JUMP);
  endfunction

endpackage

// File: rtl/fighter_pose_sequencer_if.sv
// Command, draw-coordinate and pixel bundle
// between keycode decoder, sequencer and colour mapper.
interface fighter_pose_sequencer_if;
  import fighter_pkg::*;

  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic       btn_crouch;
  logic       btn_punch;
  logic       btn_kick;
  logic       btn_block;
  logic       health_zero;
  logic       facing_left;
  logic [9:0] drawx;
  logic [9:0] drawy;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic [11:0] rom_addr;
  pose_t      pose_sel;
  pose_t      pix_pose;
  logic       pix_valid;
  logic       attack_active;
  logic       attack_start;

  modport master (
    output frame_tick, btn_left, btn_right,
    output btn_jump, btn_crouch, btn_punch,
    output btn_kick, btn_block, health_zero,
    output facing_left, drawx, drawy,
    output sprite_x, sprite_y,
    input  rom_addr, pose_sel, pix_pose,
    input  pix_valid, attack_active, attack_start
  );

  modport slave (
    input  frame_tick, btn_left, btn_right,
    input  btn_jump, btn_crouch, btn_punch,
    input  btn_kick, btn_block, health_zero,
    input  facing_left, drawx, drawy,
    input  sprite_x, sprite_y,
    output rom_addr, pose_sel, pix_pose,
    output pix_valid, attack_active, attack_start
  );

endinterface

// File: rtl/fighter_pose_sequencer_sprite_addr_gen.sv
// Sprite ROM address generator with horizontal flip.
// Two register stages line pixel flags up with ROM q.
module sprite_addr_gen
  import fighter_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  drawx,
  input  logic [9:0]  drawy,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        facing_left,
  input  pose_t       pose,
  output logic [11:0] rom_addr,
  output pose_t       pix_pose,
  output logic        pix_valid
);

  logic [9:0] dx;
  logic [9:0] dy;
  logic [5:0] xf;
  logic       inbox;
  logic       inbox_d;
  pose_t      pose_d;

  assign dx    = drawx - sprite_x;
  assign dy    = drawy - sprite_y;
  assign inbox = (dx[9:6] == 4'd0) &&
                 (dy[9:6] == 4'd0);
  assign xf    = facing_left ? ~dx[5:0] : dx[5:0];

  // Stage 1: address the ROM, remember box hit and pose
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
      inbox_d  <= 1'b0;
      pose_d   <= STAND;
    end else begin
      rom_addr <= inbox ? {dy[5:0], xf} : 12'd0;
      inbox_d  <= inbox;
      pose_d   <= pose;
    end
  end

  // Stage 2: flags aligned with the ROM read data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_pose  <= STAND;
    end else begin
      pix_valid <= inbox_d;
      pix_pose  <= pose_d;
    end
  end

endmodule

// File: rtl/fighter_pose_sequencer.sv
// Per-fighter pose state machine advancing on frame ticks,
// plus the shared pose ROM address path.
module fighter_pose_sequencer
  import fighter_pkg::*;
#(
  parameter int IDLE_FRAMES  = 20,
  parameter int PUNCH_FRAMES = 12,
  parameter int KICK_FRAMES  = 16,
  parameter int JUMP_FRAMES  = 30
) (
  input logic clock,
  input logic reset,
  fighter_pose_sequencer_if.slave bus
);

  pose_t      state;
  pose_t      nxt;
  logic [4:0] tmr;
  logic [4:0] nxt_tmr;
  logic [4:0] idle;
  logic [4:0] nxt_idle;
  logic       idle_st;
  logic       mv;

  assign idle_st = (state == STAND) ||
                   (state == STAND2);
  assign mv      = bus.btn_left ^ bus.btn_right;

  // Next pose on a frame tick, in priority order
  always_comb begin
    nxt      = state;
    nxt_tmr  = tmr;
    nxt_idle = 5'd0;
    if (state == DEAD) begin
      nxt = DEAD;
    end else if (bus.health_zero) begin
      nxt = DEAD;
    end else if (is_timed(state)) begin
      if (tmr == 5'd1) begin
        nxt = (state == CROUCHPUNCH && bus.btn_crouch)
              ? CROUCH : STAND;
      end else begin
        nxt_tmr = tmr - 5'd1;
      end
    end else if (bus.btn_block) begin
      nxt = BLOCK;
    end else if (bus.btn_jump) begin
      nxt     = JUMP;
      nxt_tmr = 5'(JUMP_FRAMES);
    end else if (bus.btn_punch && bus.btn_crouch) begin
      nxt     = CROUCHPUNCH;
      nxt_tmr = 5'(PUNCH_FRAMES);
    end else if (bus.btn_punch) begin
      nxt     = PUNCH;
      nxt_tmr = 5'(PUNCH_FRAMES);
    end else if (bus.btn_kick) begin
      nxt     = KICK;
      nxt_tmr = 5'(KICK_FRAMES);
    end else if (bus.btn_crouch) begin
      nxt = CROUCH;
    end else if (mv) begin
      nxt = MOVE;
    end else if (idle_st) begin
      if (idle == 5'(IDLE_FRAMES - 1)) begin
        nxt = (state == STAND) ? STAND2 : STAND;
      end else begin
        nxt      = state;
        nxt_idle = idle + 5'd1;
      end
    end else begin
      nxt = STAND;
    end
  end

  // Pose register and attack flags, updated once per frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= STAND;
      tmr               <= '0;
      idle              <= '0;
      bus.attack_active <= 1'b0;
      bus.attack_start  <= 1'b0;
    end else if (bus.frame_tick) begin
      state             <= nxt;
      tmr               <= nxt_tmr;
      idle              <= nxt_idle;
      bus.attack_active <= is_attack(nxt);
      bus.attack_start  <= is_attack(nxt) &&
                           (nxt != state);
    end else begin
      bus.attack_start  <= 1'b0;
    end
  end

  assign bus.pose_sel = state;

  sprite_addr_gen u_addr (
    .clock       (clock),
    .reset       (reset),
    .drawx       (bus.drawx),
    .drawy       (bus.drawy),
    .sprite_x    (bus.sprite_x),
    .sprite_y    (bus.sprite_y),
    .facing_left (bus.facing_left),
    .pose        (state),
    .rom_addr    (bus.rom_addr),
    .pix_pose    (bus.pix_pose),
    .pix_valid   (bus.pix_valid)
  );

endmodule

// File: tb/tb_fighter_pose_sequencer.sv
// Directed self-checking bench for fighter_pose_sequencer.
// Each task drives one scenario and checks inline.
module tb_fighter_pose_sequencer;
  import fighter_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   fails;
  int   starts;

  fighter_pose_sequencer_if bus ();

  fighter_pose_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock)
    if (bus.attack_start === 1'b1) starts++;

  task automatic clr_btns();
    bus.btn_left    = 0;
    bus.btn_right   = 0;
    bus.btn_jump    = 0;
    bus.btn_crouch  = 0;
    bus.btn_punch   = 0;
    bus.btn_kick    = 0;
    bus.btn_block   = 0;
    bus.health_zero = 0;
  endtask

  task automatic tick();
    @(negedge clock);
    bus.frame_tick = 1'b1;
    @(posedge clock);
    #1 bus.frame_tick = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.pose_sel !== STAND || bus.rom_addr !== 12'd0 ||
        bus.pix_valid !== 1'b0 || bus.pix_pose !== STAND ||
        bus.attack_active !== 1'b0 ||
        bus.attack_start !== 1'b0) begin
      fails++;
      $display("FAIL reset: pose=%0d addr=%0d pv=%b pp=%0d aa=%b as=%b, want 0 0 0 0 0 0",
               bus.pose_sel, bus.rom_addr, bus.pix_valid,
               bus.pix_pose, bus.attack_active, bus.attack_start);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_idle();
    pose_t exp;
    for (int i = 1; i <= 25; i++) begin
      tick();
      exp = (i < 20) ? STAND : STAND2;
      checks++;
      if (bus.pose_sel !== exp) begin
        fails++;
        $display("FAIL idle tick %0d: pose=%0d want %0d",
                 i, bus.pose_sel, exp);
      end
    end
    bus.sprite_x = 10'd0;
    bus.sprite_y = 10'd0;
    bus.drawx    = 10'd5;
    bus.drawy    = 10'd5;
    step();
    step();
    step();
    checks++;
    if (bus.pix_valid !== 1'b1) begin
      fails++;
      $display("FAIL idle pv before reset: %b want 1",
               bus.pix_valid);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.pose_sel !== STAND || bus.pix_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrun reset: pose=%0d pv=%b want 0 0",
               bus.pose_sel, bus.pix_valid);
    end
    @(negedge clock);
    reset = 1'b0;
    bus.drawx = 10'd900;
  endtask

  task automatic test_punch();
    starts = 0;
    bus.btn_punch = 1'b1;
    tick();
    bus.btn_punch = 1'b0;
    checks++;
    if (bus.pose_sel !== PUNCH || bus.attack_start !== 1'b1 ||
        bus.attack_active !== 1'b1) begin
      fails++;
      $display("FAIL punch entry: pose=%0d as=%b aa=%b want 4 1 1",
               bus.pose_sel, bus.attack_start, bus.attack_active);
    end
    for (int k = 1; k < 12; k++) begin
      tick();
      checks++;
      if (bus.pose_sel !== PUNCH || bus.attack_active !== 1'b1) begin
        fails++;
        $display("FAIL punch hold %0d: pose=%0d aa=%b want 4 1",
                 k, bus.pose_sel, bus.attack_active);
      end
    end
    tick();
    checks++;
    if (bus.pose_sel !== STAND || bus.attack_active !== 1'b0) begin
      fails++;
      $display("FAIL punch exit: pose=%0d aa=%b want 0 0",
               bus.pose_sel, bus.attack_active);
    end
    checks++;
    if (starts !== 1) begin
      fails++;
      $display("FAIL punch start pulses: %0d want 1", starts);
    end
  endtask

  task automatic test_crouchpunch();
    bus.btn_crouch = 1'b1;
    bus.btn_punch  = 1'b1;
    tick();
    bus.btn_punch  = 1'b0;
    checks++;
    if (bus.pose_sel !== CROUCHPUNCH || bus.attack_start !== 1'b1) begin
      fails++;
      $display("FAIL cpunch entry: pose=%0d as=%b want 6 1",
               bus.pose_sel, bus.attack_start);
    end
    for (int k = 1; k < 12; k++) begin
      if (k == 5) bus.btn_kick = 1'b1;
      tick();
      checks++;
      if (bus.pose_sel !== CROUCHPUNCH) begin
        fails++;
        $display("FAIL cpunch hold %0d: pose=%0d want 6",
                 k, bus.pose_sel);
      end
    end
    tick();
    checks++;
    if (bus.pose_sel !== CROUCH) begin
      fails++;
      $display("FAIL cpunch exit: pose=%0d want 1", bus.pose_sel);
    end
    clr_btns();
    tick();
    checks++;
    if (bus.pose_sel !== STAND) begin
      fails++;
      $display("FAIL crouch release: pose=%0d want 0", bus.pose_sel);
    end
  endtask

  task automatic test_jump_dead();
    bus.btn_jump = 1'b1;
    tick();
    bus.btn_jump = 1'b0;
    for (int k = 1; k < 10; k++) begin
      checks++;
      if (bus.pose_sel !== JUMP) begin
        fails++;
        $display("FAIL jump tick %0d: pose=%0d want 2",
                 k, bus.pose_sel);
      end
      tick();
    end
    bus.health_zero = 1'b1;
    tick();
    bus.health_zero = 1'b0;
    checks++;
    if (bus.pose_sel !== DEAD) begin
      fails++;
      $display("FAIL jump to dead: pose=%0d want 7", bus.pose_sel);
    end
    for (int k = 0; k < 50; k++) begin
      bus.btn_left    = 1'($urandom_range(0, 1));
      bus.btn_right   = 1'($urandom_range(0, 1));
      bus.btn_jump    = 1'($urandom_range(0, 1));
      bus.btn_crouch  = 1'($urandom_range(0, 1));
      bus.btn_punch   = 1'($urandom_range(0, 1));
      bus.btn_kick    = 1'($urandom_range(0, 1));
      bus.btn_block   = 1'($urandom_range(0, 1));
      bus.health_zero = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (bus.pose_sel !== DEAD || bus.attack_active !== 1'b0) begin
        fails++;
        $display("FAIL dead hold %0d: pose=%0d aa=%b want 7 0",
                 k, bus.pose_sel, bus.attack_active);
      end
    end
    clr_btns();
    do_reset();
    checks++;
    if (bus.pose_sel !== STAND) begin
      fails++;
      $display("FAIL dead reset: pose=%0d want 0", bus.pose_sel);
    end
  endtask

  task automatic test_addr();
    bus.btn_crouch = 1'b1;
    tick();
    bus.btn_crouch = 1'b0;
    bus.sprite_x    = 10'd100;
    bus.sprite_y    = 10'd200;
    bus.drawx       = 10'd103;
    bus.drawy       = 10'd205;
    bus.facing_left = 1'b0;
    step();
    checks++;
    if (bus.rom_addr !== 12'd323) begin
      fails++;
      $display("FAIL addr right: %0d want 323", bus.rom_addr);
    end
    bus.facing_left = 1'b1;
    step();
    checks++;
    if (bus.pix_valid !== 1'b1 || bus.pix_pose !== CROUCH) begin
      fails++;
      $display("FAIL pix right: pv=%b pp=%0d want 1 1",
               bus.pix_valid, bus.pix_pose);
    end
    checks++;
    if (bus.rom_addr !== 12'd380) begin
      fails++;
      $display("FAIL addr flip: %0d want 380", bus.rom_addr);
    end
    bus.drawx = 10'd99;
    step();
    checks++;
    if (bus.rom_addr !== 12'd0 || bus.pix_valid !== 1'b1) begin
      fails++;
      $display("FAIL addr wrap: addr=%0d pv=%b want 0 1",
               bus.rom_addr, bus.pix_valid);
    end
    bus.facing_left = 1'b0;
    bus.drawx       = 10'd163;
    bus.drawy       = 10'd263;
    step();
    checks++;
    if (bus.pix_valid !== 1'b0) begin
      fails++;
      $display("FAIL pv wrap: %b want 0", bus.pix_valid);
    end
    checks++;
    if (bus.rom_addr !== 12'd4095) begin
      fails++;
      $display("FAIL addr corner: %0d want 4095", bus.rom_addr);
    end
    bus.drawx = 10'd164;
    step();
    checks++;
    if (bus.rom_addr !== 12'd0 || bus.pix_valid !== 1'b1) begin
      fails++;
      $display("FAIL addr edge: addr=%0d pv=%b want 0 1",
               bus.rom_addr, bus.pix_valid);
    end
    step();
    checks++;
    if (bus.pix_valid !== 1'b0) begin
      fails++;
      $display("FAIL pv edge: %b want 0", bus.pix_valid);
    end
    tick();
    checks++;
    if (bus.pose_sel !== STAND) begin
      fails++;
      $display("FAIL addr pose back: %0d want 0", bus.pose_sel);
    end
  endtask

  task automatic test_left_right();
    bus.btn_left  = 1'b1;
    bus.btn_right = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (bus.pose_sel !== STAND) begin
        fails++;
        $display("FAIL left+right %0d: pose=%0d want 0",
                 k, bus.pose_sel);
      end
    end
    bus.btn_right = 1'b0;
    tick();
    checks++;
    if (bus.pose_sel !== MOVE) begin
      fails++;
      $display("FAIL move: pose=%0d want 9", bus.pose_sel);
    end
    bus.btn_left = 1'b0;
    tick();
    checks++;
    if (bus.pose_sel !== STAND) begin
      fails++;
      $display("FAIL move stop: pose=%0d want 0", bus.pose_sel);
    end
  endtask

  initial begin
    checks          = 0;
    fails           = 0;
    starts          = 0;
    reset           = 1'b0;
    bus.frame_tick  = 1'b0;
    bus.facing_left = 1'b0;
    bus.drawx       = 10'd900;
    bus.drawy       = 10'd900;
    bus.sprite_x    = 10'd0;
    bus.sprite_y    = 10'd0;
    clr_btns();
    test_reset();
    test_idle();
    test_punch();
    test_crouchpunch();
    test_jump_dead();
    test_addr();
    test_left_right();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
